// File: rtl/interlude_pkg.sv
// rtl/interlude_pkg.sv - shared state, opcode, ALU and condition encodings for the interlude core
package interlude_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam int NUM_REGS = 8;

  localparam logic [1:0] CLS_IMM = 2'b00;
  localparam logic [1:0] CLS_ALU = 2'b01;
  localparam logic [1:0] CLS_MOV = 2'b10;
  localparam logic [1:0] CLS_CTL = 2'b11;

  localparam logic [5:0] ALU_OR   = 6'd0;
  localparam logic [5:0] ALU_NAND = 6'd1;
  localparam logic [5:0] ALU_NOR  = 6'd2;
  localparam logic [5:0] ALU_AND  = 6'd3;
  localparam logic [5:0] ALU_ADD  = 6'd4;
  localparam logic [5:0] ALU_SUB  = 6'd5;
  localparam logic [5:0] ALU_XOR  = 6'd6;
  localparam logic [5:0] ALU_SHL  = 6'd7;

  localparam logic [2:0] COND_HALT = 3'd0;
  localparam logic [2:0] COND_EQZ  = 3'd1;
  localparam logic [2:0] COND_LTZ  = 3'd2;
  localparam logic [2:0] COND_LEZ  = 3'd3;
  localparam logic [2:0] COND_ALW  = 3'd4;
  localparam logic [2:0] COND_NEZ  = 3'd5;
  localparam logic [2:0] COND_GEZ  = 3'd6;
  localparam logic [2:0] COND_GTZ  = 3'd7;

  localparam logic [2:0] REG_IMM   = 3'd0;
  localparam logic [2:0] REG_ALU_A = 3'd1;
  localparam logic [2:0] REG_ALU_B = 3'd2;
  localparam logic [2:0] REG_ALU_Y = 3'd3;
  localparam logic [2:0] REG_IO    = 3'd7;

endpackage

// File: rtl/interlude_alu.sv
// rtl/interlude_alu.sv - combinational ALU and signed branch-condition evaluation
module interlude_alu
  import interlude_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [5:0]        i_op,
  input  logic [DATA_W-1:0] i_cond_val,
  input  logic [2:0]        i_cond,
  output logic [DATA_W-1:0] o_y,
  output logic              o_taken
);

  localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);

  logic w_zero;
  logic w_neg;

  assign w_zero = (i_cond_val == '0);
  assign w_neg  = i_cond_val[DATA_W-1];

  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_OR:   o_y = i_a | i_b;
      ALU_NAND: o_y = ~(i_a & i_b);
      ALU_NOR:  o_y = ~(i_a | i_b);
      ALU_AND:  o_y = i_a & i_b;
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_XOR:  o_y = i_a ^ i_b;
      // Shifting by the full width or more must give zero, not a tool-dependent result
      ALU_SHL:  o_y = (i_b >= SHIFT_LIM) ? '0 : (i_a << i_b);
      default:  o_y = '0;
    endcase
  end

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_EQZ:  o_taken = w_zero;
      COND_LTZ:  o_taken = w_neg;
      COND_LEZ:  o_taken = w_neg | w_zero;
      COND_ALW:  o_taken = 1'b1;
      COND_NEZ:  o_taken = ~w_zero;
      COND_GEZ:  o_taken = ~w_neg;
      COND_GTZ:  o_taken = ~w_neg & ~w_zero;
      COND_HALT: o_taken = 1'b0;
      default:   o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/interlude_core.sv
// rtl/interlude_core.sv - fetch/execute byte-code core with eight registers
// Optional INTERLUDE_IO_EN: r7 reads return io_in, r7 writes only drive io_out.
module interlude_core
  import interlude_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_data,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out,
  output logic              retire,
  output logic              halted
);

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_run;
  logic [ADDR_W-1:0]        r_pc;
  logic [7:0]               r_ir;
  logic [DATA_W-1:0]        r_regs [NUM_REGS];

  logic [1:0]               w_cls;
  logic [2:0]               w_src;
  logic [2:0]               w_dst;
  logic [2:0]               w_cond;
  logic                     w_is_halt;
  logic                     w_is_branch;
  logic                     w_taken;
  logic [DATA_W-1:0]        w_src_val;
  logic [DATA_W-1:0]        w_alu_y;
  logic [ADDR_W+DATA_W-1:0] w_r0_ext;
  logic [ADDR_W-1:0]        w_target;
  logic [ADDR_W-1:0]        w_pc_inc;
  logic [ADDR_W-1:0]        w_pc_next;

  assign w_cls       = r_ir[7:6];
  assign w_src       = r_ir[5:3];
  assign w_dst       = r_ir[2:0];
  assign w_cond      = r_ir[2:0];
  assign w_is_halt   = (w_cls == CLS_CTL) && (w_cond == COND_HALT);
  assign w_is_branch = (w_cls == CLS_CTL) && (w_cond != COND_HALT);

`ifdef INTERLUDE_IO_EN
  assign w_src_val = (w_src == REG_IO) ? io_in : r_regs[w_src];
`else
  logic w_unused_io;
  assign w_src_val   = r_regs[w_src];
  assign w_unused_io = ^io_in;
`endif

  interlude_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_a        (r_regs[REG_ALU_A]),
    .i_b        (r_regs[REG_ALU_B]),
    .i_op       (r_ir[5:0]),
    .i_cond_val (r_regs[REG_ALU_Y]),
    .i_cond     (w_cond),
    .o_y        (w_alu_y),
    .o_taken    (w_taken)
  );

  // Widening first makes the target a plain zero-extend or truncate of r0 for any width pair
  assign w_r0_ext = {{ADDR_W{1'b0}}, r_regs[REG_IMM]};
  assign w_target = w_r0_ext[ADDR_W-1:0];
  assign w_pc_inc = r_pc + ADDR_W'(1);

  always_comb begin
    w_pc_next = w_pc_inc;
    if (w_is_halt) begin
      w_pc_next = r_pc;
    end else if (w_is_branch && w_taken) begin
      w_pc_next = w_target;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH: if (imem_req && imem_ack) w_next = ST_EXEC;
      ST_EXEC:  w_next = w_is_halt ? ST_HALT : ST_FETCH;
      ST_HALT:  w_next = ST_HALT;
      default:  w_next = ST_FETCH;
    endcase
  end

  // r_run keeps the request low while reset is held and for the state reset leaves behind
  always_comb begin
    imem_req = r_run && (r_state == ST_FETCH);
    retire   = (r_state == ST_EXEC);
    halted   = (r_state == ST_HALT);
  end

  assign imem_addr = r_pc;
  assign io_out    = r_regs[REG_IO];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run <= 1'b0;
      r_pc  <= '0;
      r_ir  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_run <= 1'b1;
      if (imem_req && imem_ack) begin
        r_ir <= imem_data;
      end
      if (r_state == ST_EXEC) begin
        r_pc <= w_pc_next;
        case (w_cls)
          CLS_IMM: r_regs[REG_IMM] <= DATA_W'(r_ir[5:0]);
          CLS_ALU: r_regs[REG_ALU_Y] <= w_alu_y;
          CLS_MOV: if (w_src != w_dst) r_regs[w_dst] <= w_src_val;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_interlude_core.sv
// tb/tb_interlude_core.sv - randomized and directed checks of interlude_core against an instruction-level model
`timescale 1ns/1ps
module tb_interlude_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_req, a_ret, a_halt;
  logic        a_ack = 1'b0;
  logic [7:0]  a_addr, a_io_out;
  logic [7:0]  a_data = 8'h00;
  logic [7:0]  a_io_in = 8'h00;

  logic        b_req, b_ret, b_halt;
  logic        b_ack = 1'b0;
  logic [3:0]  b_addr;
  logic [7:0]  b_data = 8'h00;
  logic [15:0] b_io_in = 16'h0000;
  logic [15:0] b_io_out;

  interlude_core #(.DATA_W(8), .ADDR_W(8)) u_dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .imem_req  (a_req),
    .imem_addr (a_addr),
    .imem_ack  (a_ack),
    .imem_data (a_data),
    .io_in     (a_io_in),
    .io_out    (a_io_out),
    .retire    (a_ret),
    .halted    (a_halt)
  );

  interlude_core #(.DATA_W(16), .ADDR_W(4)) u_dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .imem_req  (b_req),
    .imem_addr (b_addr),
    .imem_ack  (b_ack),
    .imem_data (b_data),
    .io_in     (b_io_in),
    .io_out    (b_io_out),
    .retire    (b_ret),
    .halted    (b_halt)
  );

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [16];
  int         lat = 1;
  int         n_checks = 0;
  int         n_errors = 0;
  int         a_cnt = 0;
  int         b_cnt = 0;
  logic [7:0] a_hold = 8'h00;
  logic [3:0] b_hold = 4'h0;
  int         a_retired;
  int         b_retired;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_retired <= 0;
      b_retired <= 0;
    end else begin
      if (a_ret) a_retired <= a_retired + 1;
      if (b_ret) b_retired <= b_retired + 1;
    end
  end

  // Memory responders: ack arrives on the lat-th cycle of a held request
  always @(negedge clk) begin
    if (!reset_n || !a_req) begin
      a_cnt = 0;
      a_ack = 1'b0;
    end else begin
      if (a_cnt > 0) check("a_addr_hold", a_addr, a_hold);
      a_hold = a_addr;
      a_cnt++;
      if (a_cnt >= lat) begin
        a_ack  = 1'b1;
        a_data = mem_a[a_addr];
        a_cnt  = 0;
      end else begin
        a_ack = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n || !b_req) begin
      b_cnt = 0;
      b_ack = 1'b0;
    end else begin
      if (b_cnt > 0) check("b_addr_hold", b_addr, b_hold);
      b_hold = b_addr;
      b_cnt++;
      if (b_cnt >= lat) begin
        b_ack  = 1'b1;
        b_data = mem_b[b_addr];
        b_cnt  = 0;
      end else begin
        b_ack = 1'b0;
      end
    end
  end

  task automatic model_run(input int sel, input int max_steps, output int steps,
                           output bit halt, output int pc_o, output longint r7_o);
    int     dw, aw, pc, ins, c, s, d;
    longint mask, amask, a, b, sv;
    longint r [8];
    bit     take;
    dw    = (sel != 0) ? 16 : 8;
    aw    = (sel != 0) ? 4 : 8;
    mask  = (longint'(1) << dw) - 1;
    amask = (longint'(1) << aw) - 1;
    foreach (r[i]) r[i] = 0;
    pc    = 0;
    steps = 0;
    halt  = 1'b0;
    while (steps < max_steps && !halt) begin
      ins = (sel != 0) ? int'(mem_b[pc]) : int'(mem_a[pc]);
      steps++;
      s = (ins >> 3) & 7;
      d = ins & 7;
      case (ins >> 6)
        0: begin
          r[0] = ins & 63;
          pc = int'((pc + 1) & amask);
        end
        1: begin
          a = r[1];
          b = r[2];
          case (ins & 63)
            0: r[3] = a | b;
            1: r[3] = ~(a & b);
            2: r[3] = ~(a | b);
            3: r[3] = a & b;
            4: r[3] = a + b;
            5: r[3] = a - b;
            6: r[3] = a ^ b;
            7: r[3] = (b >= dw) ? 0 : (a << b);
            default: r[3] = 0;
          endcase
          r[3] &= mask;
          pc = int'((pc + 1) & amask);
        end
        2: begin
          if (s != d) r[d] = r[s];
          pc = int'((pc + 1) & amask);
        end
        default: begin
          c = ins & 7;
          if (c == 0) begin
            halt = 1'b1;
          end else begin
            sv = (r[3] >= (longint'(1) << (dw - 1))) ? r[3] - (longint'(1) << dw) : r[3];
            case (c)
              1: take = (sv == 0);
              2: take = (sv < 0);
              3: take = (sv <= 0);
              4: take = 1'b1;
              5: take = (sv != 0);
              6: take = (sv >= 0);
              default: take = (sv > 0);
            endcase
            pc = take ? int'(r[0] & amask) : int'((pc + 1) & amask);
          end
        end
      endcase
    end
    pc_o = pc;
    r7_o = r[7];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_prog(input int sel, input int max_steps, input string tag);
    int     steps, total, pc;
    bit     halt;
    longint r7;
    model_run(sel, max_steps, steps, halt, pc, r7);
    do_reset();
    total = 1 + steps * (lat + 1);
    repeat (total - 1) @(posedge clk);
    @(negedge clk);
    if (halt) check({tag, "_halt_early"}, (sel != 0) ? b_halt : a_halt, 1'b0);
    @(negedge clk);
    check({tag, "_halted"},  (sel != 0) ? b_halt : a_halt, halt);
    check({tag, "_retired"}, (sel != 0) ? b_retired : a_retired, steps);
    check({tag, "_io_out"},  (sel != 0) ? 64'(b_io_out) : 64'(a_io_out), r7);
    check({tag, "_pc"},      (sel != 0) ? 64'(b_addr) : 64'(a_addr), pc);
    check({tag, "_req"},     (sel != 0) ? b_req : a_req, !halt);
  endtask

  function automatic logic [7:0] rand_ins();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0, 1:    return 8'($urandom_range(0, 63));
      2, 3:    return 8'h40 | 8'($urandom_range(0, 9));
      4, 5:    return 8'h80 | 8'($urandom_range(0, 63));
      6:       return 8'h87 | 8'($urandom_range(0, 6) << 3);
      7, 8:    return 8'hC0 | 8'($urandom_range(0, 7) << 3) | 8'($urandom_range(1, 7));
      default: return 8'hC0 | 8'($urandom_range(0, 7) << 3);
    endcase
  endfunction

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_req"},    {a_req, b_req}, 2'b00);
    check({tag, "_addr"},   a_addr, 8'h00);
    check({tag, "_io_out"}, a_io_out, 8'h00);
    check({tag, "_retire"}, {a_ret, b_ret}, 2'b00);
    check({tag, "_halted"}, {a_halt, b_halt}, 2'b00);
  endtask

  initial begin
    foreach (mem_a[i]) mem_a[i] = 8'hC0;
    foreach (mem_b[i]) mem_b[i] = 8'hC0;
    #1;
    reset_outputs_zero("rst0");

    {mem_a[0], mem_a[1], mem_a[2], mem_a[3], mem_a[4], mem_a[5], mem_a[6]} =
      {8'h05, 8'h81, 8'h02, 8'h82, 8'h44, 8'h9F, 8'hC0};
    lat = 1;
    run_prog(0, 100, "prog_ack1");
    check("prog_ack1_io7", a_io_out, 8'd7);
    check("prog_ack1_ret7", a_retired, 7);
    lat = 3;
    run_prog(0, 100, "prog_ack3");
    check("prog_ack3_io7", a_io_out, 8'd7);
    check("prog_ack3_ret7", a_retired, 7);

    @(negedge clk);
    reset_n = 1'b0;
    #1;
    reset_outputs_zero("rst_halt");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_halt_refetch_req", a_req, 1'b1);
    check("rst_halt_refetch_addr", a_addr, 8'h00);

    lat = 1;
    do_reset();
    repeat (3) @(posedge clk);
    lat = 1000;
    repeat (12) @(negedge clk);
    check("stall_req", a_req, 1'b1);
    check("stall_addr", a_addr, 8'h01);
    check("stall_retired", a_retired, 1);
    reset_n = 1'b0;
    #1;
    reset_outputs_zero("rst_fetch");
    lat = 1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_fetch_refetch_req", a_req, 1'b1);
    check("rst_fetch_refetch_addr", a_addr, 8'h00);

    foreach (mem_a[i]) mem_a[i] = 8'hC0;
    {mem_a[0], mem_a[1], mem_a[2]} = {8'h42, 8'h0A, 8'hC2};
    {mem_a[10], mem_a[11], mem_a[12]} = {8'h43, 8'hC7, 8'hC0};
    lat = 2;
    run_prog(0, 100, "branch");
    check("branch_pc12", a_addr, 8'd12);
    check("branch_ret6", a_retired, 6);

    foreach (mem_a[i]) mem_a[i] = 8'hC0;
    {mem_a[0], mem_a[1], mem_a[2], mem_a[255]} = {8'h42, 8'h98, 8'hC4, 8'h01};
    lat = 1;
    run_prog(0, 4, "wrap_a");
    check("wrap_a_pc0", a_addr, 8'h00);

    {mem_b[0], mem_b[1], mem_b[2],  mem_b[3],  mem_b[4],  mem_b[5],  mem_b[6],  mem_b[7]} =
      {8'h42, 8'h99, 8'h8F, 8'h01, 8'h82, 8'h44, 8'h9F, 8'h10};
    {mem_b[8], mem_b[9], mem_b[10], mem_b[11], mem_b[12], mem_b[13], mem_b[14], mem_b[15]} =
      {8'h82, 8'h8F, 8'h47, 8'h9F, 8'h00, 8'h00, 8'h00, 8'h00};
    run_prog(1, 3, "w16_ones");
    check("w16_ones_io", b_io_out, 16'hFFFF);
    run_prog(1, 7, "w16_add");
    check("w16_add_wrap", b_io_out, 16'h0000);
    run_prog(1, 10, "w16_pre_shl");
    check("w16_pre_shl_io", b_io_out, 16'hFFFF);
    run_prog(1, 12, "w16_shl");
    check("w16_shl16", b_io_out, 16'h0000);
    run_prog(1, 15, "w16_pc15");
    check("w16_pc15_addr", b_addr, 4'hF);
    run_prog(1, 16, "w16_wrap");
    check("w16_wrap_addr", b_addr, 4'h0);

    for (int it = 0; it < 24; it++) begin
      int sel;
      sel     = (it % 4 == 3) ? 1 : 0;
      lat     = $urandom_range(1, 3);
      a_io_in = 8'($urandom);
      b_io_in = 16'($urandom);
      foreach (mem_a[i]) mem_a[i] = rand_ins();
      foreach (mem_b[i]) mem_b[i] = rand_ins();
      run_prog(sel, $urandom_range(8, 40), $sformatf("rnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
